// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: merges core fetch and data ports onto one memory port, one transaction at a time.
// Optional MEM_ARB_TIMEOUT_EN: bounds the WAIT state to TIMEOUT_CYCLES and raises a sticky err_o.
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              im_req_i,
   input  logic [ADDR_W-1:0] im_addr_i,
   output logic [DATA_W-1:0] im_dout_o,
   output logic              im_busy_o,
   input  logic              dm_en_i,
   input  logic              dm_wen_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_din_i,
   output logic [DATA_W-1:0] dm_dout_o,
   output logic              dm_busy_o,
   output logic              mem_en_o,
   output logic              mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i,
   input  logic              mem_ready_i,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state;
   logic        src_dm;
   logic        im_done_q;
   logic        dm_done_q;
   logic        dm_take;
   logic        im_take;
   logic        timeout;
   logic        finish;
   logic [DATA_W-1:0] rdata;

   // done_q masks the still-held request for one cycle so the core can consume the result
   assign dm_take   = dm_en_i & ~dm_done_q;
   assign im_take   = im_req_i & ~im_done_q;
   assign im_busy_o = im_req_i & ~im_done_q;
   assign dm_busy_o = dm_en_i & ~dm_done_q;

   assign finish = (state == WAIT) & (mem_ready_i | timeout);
   assign rdata  = mem_ready_i ? mem_dout_i : '0;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // a real ready in the same cycle wins, so timeout is only raised without one
   assign timeout = (state == WAIT) & ~mem_ready_i & (cnt == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt   <= '0;
         err_o <= 1'b0;
      end else begin
         if (state == REQ)
            cnt <= '0;
         else if (state == WAIT && !mem_ready_i)
            cnt <= cnt + 1'b1;
         if (timeout)
            err_o <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         src_dm     <= 1'b0;
         im_done_q  <= 1'b0;
         dm_done_q  <= 1'b0;
         im_dout_o  <= '0;
         dm_dout_o  <= '0;
         mem_en_o   <= 1'b0;
         mem_wen_o  <= 1'b0;
         mem_addr_o <= '0;
         mem_din_o  <= '0;
      end else begin
         mem_en_o  <= 1'b0;
         im_done_q <= 1'b0;
         dm_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (dm_take) begin
                  state      <= REQ;
                  mem_en_o   <= 1'b1;
                  src_dm     <= 1'b1;
                  mem_addr_o <= dm_addr_i;
                  mem_wen_o  <= dm_wen_i;
                  mem_din_o  <= dm_din_i;
               end else if (im_take) begin
                  state      <= REQ;
                  mem_en_o   <= 1'b1;
                  src_dm     <= 1'b0;
                  mem_addr_o <= im_addr_i;
                  mem_wen_o  <= 1'b0;
                  mem_din_o  <= '0;
               end
            end
            REQ: state <= WAIT;
            WAIT: begin
               if (finish) begin
                  state <= IDLE;
                  if (src_dm) begin
                     dm_done_q <= 1'b1;
                     if (!mem_wen_o)
                        dm_dout_o <= rdata;
                  end else begin
                     im_done_q <= 1'b1;
                     im_dout_o <= rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
